// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed 7-segment scanner with inter-digit blanking, frame-synchronous
// latching and 16-level PWM brightness.
module seven_seg_scan #(
  parameter int DIGITS       = 4,
  parameter int DIV_BITS     = 16,
  parameter int BLANK_CYCLES = 256,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [3:0]            brightness,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIV_BITS-1:0] BL = DIV_BITS'(BLANK_CYCLES);
  typedef enum logic {BLANK, ON} state_e;
  state_e state_q, state_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0] sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic [7:0] seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic frame_q, frame_d;
  logic slot_end, wrap, dig_on, seg_on;
  logic [3:0] nib;
  logic [7:0] lit;
  logic [DIGITS-1:0] one_hot;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction
  always_comb begin
    slot_end  = &cnt_q;
    wrap      = slot_end && (idx_q == IW'(DIGITS-1));
    cnt_d     = cnt_q + 1'b1;
    idx_d     = slot_end ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    state_d   = (cnt_d < BL) ? BLANK : ON;
    sh_val_d  = load ? value : sh_val_q;
    sh_dp_d   = load ? dp_in : sh_dp_q;
    sh_en_d   = load ? digit_en : sh_en_q;
    // a load landing on the boundary cycle bypasses the shadow so it shows this frame
    act_val_d = wrap ? (load ? value : sh_val_q) : act_val_q;
    act_dp_d  = wrap ? (load ? dp_in : sh_dp_q) : act_dp_q;
    act_en_d  = wrap ? (load ? digit_en : sh_en_q) : act_en_q;
    nib       = act_val_q[{idx_q, 2'b00} +: 4];
    lit       = {act_dp_q[idx_q], decode(nib)};
    one_hot   = '0;
    one_hot[idx_q] = 1'b1;
    dig_on    = (state_q == ON) && act_en_q[idx_q];
    seg_on    = dig_on && (cnt_q[DIV_BITS-1 -: 4] < brightness);
    seg_d     = seg_on ? (ACTIVE_LOW ? ~lit : lit) : SEG_OFF;
    sel_d     = dig_on ? (ACTIVE_LOW ? ~one_hot : one_hot) : SEL_OFF;
    frame_d   = wrap;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_en_q  <= '0;
      seg_q     <= SEG_OFF;
      sel_q     <= SEL_OFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_en_q  <= act_en_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end
  assign seg   = seg_q;
  assign sel   = sel_q;
  assign frame = frame_q;
endmodule
